// File: rtl/gpsreceiver2_pkg.sv
// Shared encodings for the GPS receiver sample-capture controller:
// FSM states, CSR offsets, CTRL/IRQ bit positions and the LEN clamp helper.
package gpsreceiver2_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 11;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_LEN  = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_IRQ  = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_TRIG    = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_CONT    = 4;
  localparam int CTRL_BUSY    = 8;
  localparam int CTRL_DONE    = 9;
  localparam int IRQ_DONE     = 0;
  localparam int IRQ_HALF     = 1;
  localparam int STAT_OVERRUN = 16;

  localparam logic [11:0] LEN_MAX = 12'h800;

  // A zero or oversized length means "fill the whole buffer".
  function automatic logic [11:0] clamp_len(input logic [11:0] raw);
    if ((raw == 12'h000) || (raw > LEN_MAX)) begin
      clamp_len = LEN_MAX;
    end else begin
      clamp_len = raw;
    end
  endfunction

endpackage

// File: rtl/gpsreceiver2_capture_csr.sv
// CSR bank for the capture controller: CTRL/LEN/STAT/IRQ registers, readback
// and pending-bit logic. Continuous mode and overrun exist only with GPSRX_CAPTURE_PINGPONG_EN.
module gpsreceiver2_capture_csr
  import gpsreceiver2_pkg::*;
#(
  parameter logic [3:0] csr_addr   = 4'h0,
  parameter int         DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [13:0]           csr_a,
  input  logic                  csr_we,
  input  logic [31:0]           csr_di,
  output logic [31:0]           csr_do,
  output logic                  irq,
  input  logic                  busy,
  input  logic                  done,
  input  logic [DEPTH_LOG2-1:0] ptr,
  input  logic                  capture_entry,
  input  logic                  done_set,
  input  logic                  half_set,
  output logic                  start,
  output logic                  abort,
  output logic                  trig_mode,
  output logic                  cont,
  output logic [11:0]           len
);

  logic        sel_s, wr_ctrl_s, wr_len_s, wr_irq_s;
  logic        start_r, abort_r, trig_r, irq_en_r;
  logic        done_pend_r, half_pend_r, cont_s, overrun_s;
  logic [11:0] len_r;
  logic [31:0] rdata_s, csr_do_r;

  assign sel_s     = (csr_a[13:10] == csr_addr);
  assign wr_ctrl_s = csr_we & sel_s & (csr_a[1:0] == REG_CTRL);
  assign wr_len_s  = csr_we & sel_s & (csr_a[1:0] == REG_LEN);
  assign wr_irq_s  = csr_we & sel_s & (csr_a[1:0] == REG_IRQ);

  // Control and length registers; start/abort are one-cycle strobes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      start_r  <= 1'b0;
      abort_r  <= 1'b0;
      trig_r   <= 1'b0;
      irq_en_r <= 1'b0;
      len_r    <= 12'h000;
    end else begin
      start_r <= wr_ctrl_s & csr_di[CTRL_START] & ~csr_di[CTRL_ABORT];
      abort_r <= wr_ctrl_s & csr_di[CTRL_ABORT];
      if (wr_ctrl_s) begin
        trig_r   <= csr_di[CTRL_TRIG];
        irq_en_r <= csr_di[CTRL_IRQ_EN];
      end
      if (wr_len_s) begin
        len_r <= csr_di[11:0];
      end
    end
  end

  // Pending bits: write-1-clear, but a coincident hardware set wins.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_pend_r <= 1'b0;
      half_pend_r <= 1'b0;
    end else begin
      done_pend_r <= done_set | (done_pend_r & ~(wr_irq_s & csr_di[IRQ_DONE]));
      half_pend_r <= half_set | (half_pend_r & ~(wr_irq_s & csr_di[IRQ_HALF]));
    end
  end

`ifdef GPSRX_CAPTURE_PINGPONG_EN
  logic cont_r, overrun_r;

  // Continuous-mode bit and sticky overrun (a pend bit re-set before being serviced).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cont_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        cont_r <= csr_di[CTRL_CONT];
      end
      if (capture_entry) begin
        overrun_r <= 1'b0;
      end else if ((done_set & done_pend_r) | (half_set & half_pend_r)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign cont_s    = cont_r;
  assign overrun_s = overrun_r;
`else
  assign cont_s    = 1'b0;
  assign overrun_s = 1'b0;
`endif

  // Readback mux for the addressed register.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (csr_a[1:0])
      REG_CTRL: begin
        rdata_s[CTRL_TRIG]   = trig_r;
        rdata_s[CTRL_IRQ_EN] = irq_en_r;
        rdata_s[CTRL_CONT]   = cont_s;
        rdata_s[CTRL_BUSY]   = busy;
        rdata_s[CTRL_DONE]   = done;
      end
      REG_LEN:  rdata_s[11:0] = len_r;
      REG_STAT: begin
        rdata_s[DEPTH_LOG2-1:0] = ptr;
        rdata_s[STAT_OVERRUN]   = overrun_s;
      end
      REG_IRQ: begin
        rdata_s[IRQ_DONE] = done_pend_r;
        rdata_s[IRQ_HALF] = half_pend_r;
      end
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  // Registered read data; other banks read as zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_do_r <= 32'h0000_0000;
    end else begin
      csr_do_r <= sel_s ? rdata_s : 32'h0000_0000;
    end
  end

  assign csr_do    = csr_do_r;
  assign irq       = irq_en_r & (done_pend_r | half_pend_r);
  assign start     = start_r;
  assign abort     = abort_r;
  assign trig_mode = trig_r;
  assign cont      = cont_s;
  assign len       = clamp_len(len_r);

endmodule

// File: rtl/gpsreceiver2_capture_ctrl.sv
// Capture sequencer: FSM and registered byte-write port into the sample buffer.
// Optional ping-pong continuous capture is enabled by GPSRX_CAPTURE_PINGPONG_EN.
module gpsreceiver2_capture_ctrl
  import gpsreceiver2_pkg::*;
#(
  parameter logic [3:0] csr_addr   = 4'h0,
  parameter int         DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [13:0]           csr_a,
  input  logic                  csr_we,
  input  logic [31:0]           csr_di,
  output logic [31:0]           csr_do,
  output logic                  irq,
  input  logic [7:0]            sample_dat,
  input  logic                  sample_stb,
  input  logic                  pps,
  output logic [7:0]            rxb0_dat,
  output logic [DEPTH_LOG2-1:0] rxb0_adr,
  output logic                  rxb0_we
);

  logic [1:0]            state_r, state_s;
  logic [DEPTH_LOG2-1:0] ptr_r, adr_r;
  logic [11:0]           count_r, len_s;
  logic [7:0]            dat_r;
  logic                  we_r, pps_d_r;
  logic                  start_s, abort_s, trig_s, cont_s;
  logic                  busy_s, wr_s, last_s, entry_s, done_set_s, half_set_s;

  assign busy_s  = (state_r == ST_WAIT_TRIG) | (state_r == ST_CAPTURE);
  assign wr_s    = (state_r == ST_CAPTURE) & sample_stb & ~abort_s;
  assign last_s  = wr_s & ~cont_s & ((count_r + 12'd1) == len_s);
  assign entry_s = (state_s == ST_CAPTURE) & (state_r != ST_CAPTURE);

`ifdef GPSRX_CAPTURE_PINGPONG_EN
  assign half_set_s = wr_s & cont_s & (ptr_r == DEPTH_LOG2'((1 << (DEPTH_LOG2 - 1)) - 1));
  assign done_set_s = last_s | (wr_s & cont_s & (&ptr_r));
`else
  assign half_set_s = 1'b0;
  assign done_set_s = last_s;
`endif

  // Next-state logic; abort overrides everything, start only acts when idle/done.
  always_comb begin
    state_s = state_r;
    if (abort_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_s) state_s = trig_s ? ST_WAIT_TRIG : ST_CAPTURE;
          else         state_s = state_r;
        end
        ST_WAIT_TRIG: begin
          if (pps & ~pps_d_r) state_s = ST_CAPTURE;
          else                state_s = state_r;
        end
        ST_CAPTURE: begin
          if (last_s) state_s = ST_DONE;
          else        state_s = state_r;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, write pointer/count and the registered buffer write port.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= {DEPTH_LOG2{1'b0}};
      count_r <= 12'd0;
      pps_d_r <= 1'b0;
      we_r    <= 1'b0;
      adr_r   <= {DEPTH_LOG2{1'b0}};
      dat_r   <= 8'h00;
    end else begin
      state_r <= state_s;
      pps_d_r <= pps;
      we_r    <= wr_s;
      if (wr_s) begin
        adr_r <= ptr_r;
        dat_r <= sample_dat;
      end
      if (entry_s) begin
        ptr_r   <= {DEPTH_LOG2{1'b0}};
        count_r <= 12'd0;
      end else if (wr_s) begin
        ptr_r   <= ptr_r + DEPTH_LOG2'(1);
        count_r <= count_r + 12'd1;
      end
    end
  end

  gpsreceiver2_capture_csr #(
    .csr_addr   (csr_addr),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_csr (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .csr_a         (csr_a),
    .csr_we        (csr_we),
    .csr_di        (csr_di),
    .csr_do        (csr_do),
    .irq           (irq),
    .busy          (busy_s),
    .done          (state_r == ST_DONE),
    .ptr           (ptr_r),
    .capture_entry (entry_s),
    .done_set      (done_set_s),
    .half_set      (half_set_s),
    .start         (start_s),
    .abort         (abort_s),
    .trig_mode     (trig_s),
    .cont          (cont_s),
    .len           (len_s)
  );

  assign rxb0_we  = we_r;
  assign rxb0_adr = adr_r;
  assign rxb0_dat = dat_r;

endmodule
